// File: rtl/sudoku_board_store.sv
// sudoku_board_store
// Holds the 9x9 puzzle, the player cursor and the filled-cell count.
// The renderer reads cells through rd_i/rd_j -> rd_value. Button pulses
// move the cursor and step the digit under it. A row-major 81-beat
// valid/ready stream from the puzzle ROM reloads the whole board.
//
// Ports
//   clk, reset                    system clock, async active-high reset
//   rd_i, rd_j -> rd_value        renderer cell read (0 when out of range)
//   btn_up/down/left/right        one-cycle cursor move pulses
//   btn_inc                       one-cycle digit increment pulse
//   load_start                    begin an 81-cell load
//   load_valid, load_data         load beat stream
//   load_ready                    high while a load is in progress
//   load_done                     one-cycle pulse after the last beat
//   cur_i, cur_j                  cursor position
//   filled_count, board_full      cells with a non-zero digit, == 81
//
// Build option
//   COMB_READ_EN  when defined, rd_value is combinational from rd_i/rd_j;
//                 otherwise it is registered (one-cycle latency).
//
// Cell word: [3:0] digit 0..9 (0 = empty), [4] given (fixed) flag.
//
// state | meaning
// IDLE  | buttons honoured, waiting for load_start
// LOAD  | accepting beats, load_ready high
// DONE  | load_done pulse, returns to IDLE

module sudoku_board_store #(
  parameter int N     = 9,
  parameter int IDX_W = 5,
  parameter int VAL_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_i,
  input  logic [IDX_W-1:0] rd_j,
  output logic [VAL_W-1:0] rd_value,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_inc,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [VAL_W-1:0] load_data,
  output logic             load_ready,
  output logic             load_done,
  output logic [IDX_W-1:0] cur_i,
  output logic [IDX_W-1:0] cur_j,
  output logic [6:0]       filled_count,
  output logic             board_full
);

  localparam int         CELLS = N * N;
  localparam int         CNT_W = 7;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CELLS - 1);
  localparam logic [IDX_W-1:0] MAX_IDX   = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [VAL_W-1:0] cells [CELLS];
  logic [CNT_W-1:0] beat_cnt;

  // Row-major linear index; only meaningful for in-range coordinates.
  function automatic logic [CNT_W-1:0] cell_idx(input logic [IDX_W-1:0] i,
                                                 input logic [IDX_W-1:0] j);
    return CNT_W'(i) * CNT_W'(N) + CNT_W'(j);
  endfunction

  // ---------------- read port ----------------
  logic             rd_in_range;
  logic [VAL_W-1:0] rd_word;

  always_comb begin
    rd_in_range = (rd_i < IDX_W'(N)) && (rd_j < IDX_W'(N));
    rd_word     = '0;
    if (rd_in_range) rd_word = cells[cell_idx(rd_i, rd_j)];
  end

`ifdef COMB_READ_EN
  assign rd_value = rd_word;
`else
  // Sampled from the pre-edge board, so a same-cycle write reads old data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_value <= '0;
    else       rd_value <= rd_word;
  end
`endif

  // ---------------- cursor next-state ----------------
  logic [IDX_W-1:0] nxt_i, nxt_j;

  always_comb begin
    nxt_i = cur_i;
    nxt_j = cur_j;
    if (btn_up && !btn_down)
      nxt_i = (cur_i == '0) ? MAX_IDX : cur_i - IDX_W'(1);
    else if (btn_down && !btn_up)
      nxt_i = (cur_i == MAX_IDX) ? '0 : cur_i + IDX_W'(1);
    if (btn_left && !btn_right)
      nxt_j = (cur_j == '0) ? MAX_IDX : cur_j - IDX_W'(1);
    else if (btn_right && !btn_left)
      nxt_j = (cur_j == MAX_IDX) ? '0 : cur_j + IDX_W'(1);
  end

  // ---------------- digit increment under cursor ----------------
  logic [CNT_W-1:0] cur_idx;
  logic [VAL_W-1:0] cur_word;
  logic [3:0]       inc_digit;
  logic             inc_en;

  always_comb begin
    cur_idx   = cell_idx(cur_i, cur_j);
    cur_word  = cells[cur_idx];
    inc_en    = btn_inc && !cur_word[4];
    inc_digit = (cur_word[3:0] >= 4'd9) ? 4'd0 : cur_word[3:0] + 4'd1;
  end

  // ---------------- load beat sanitising ----------------
  logic [VAL_W-1:0] load_word;
  logic             beat_fire;

  always_comb begin
    load_word      = load_data;
    if (load_data[3:0] > 4'd9) load_word[3:0] = 4'd0;
    beat_fire      = load_valid && load_ready;
  end

  // ---------------- main FSM / board ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      cur_i        <= '0;
      cur_j        <= '0;
      filled_count <= '0;
      load_ready   <= 1'b0;
      load_done    <= 1'b0;
      for (int k = 0; k < CELLS; k++) cells[k] <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          cur_i <= nxt_i;
          cur_j <= nxt_j;
          if (inc_en) begin
            cells[cur_idx][3:0] <= inc_digit;
            if (cur_word[3:0] == 4'd0)      filled_count <= filled_count + 7'd1;
            else if (inc_digit == 4'd0)     filled_count <= filled_count - 7'd1;
          end
          // Load start overrides any count adjustment from a same-cycle edit;
          // the edited cell is rewritten by the load anyway.
          if (load_start) begin
            state        <= LOAD;
            beat_cnt     <= '0;
            filled_count <= '0;
            load_ready   <= 1'b1;
          end
        end

        LOAD: begin
          if (beat_fire) begin
            cells[beat_cnt] <= load_word;
            beat_cnt        <= beat_cnt + CNT_W'(1);
            if (load_word[3:0] != 4'd0) filled_count <= filled_count + 7'd1;
            if (beat_cnt == LAST_BEAT) begin
              state      <= DONE;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state      <= IDLE;
          load_ready <= 1'b0;
        end
      endcase
    end
  end

  assign board_full = (filled_count == 7'(CELLS));

endmodule

// File: tb/tb_sudoku_board_store.sv
module tb_sudoku_board_store;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rd_i, rd_j;
  logic [4:0] rd_value;
  logic       btn_up, btn_down, btn_left, btn_right, btn_inc;
  logic       load_start, load_valid;
  logic [4:0] load_data;
  logic       load_ready, load_done;
  logic [4:0] cur_i, cur_j;
  logic [6:0] filled_count;
  logic       board_full;

  sudoku_board_store dut (
    .clk(clk), .reset(reset),
    .rd_i(rd_i), .rd_j(rd_j), .rd_value(rd_value),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_inc(btn_inc),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done),
    .cur_i(cur_i), .cur_j(cur_j),
    .filled_count(filled_count), .board_full(board_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: board as 81 words, phase 0 idle / 1 loading / 2 done.
  int m_cell [81];
  int m_ci, m_cj, m_phase, m_beats, m_rd;

  function automatic int lookup(input int i, input int j);
    if (i < 9 && j < 9) return m_cell[i*9 + j];
    return 0;
  endfunction

  function automatic int m_filled();
    int n = 0;
    int lim = (m_phase == 1) ? m_beats : 81;
    for (int k = 0; k < lim; k++) if (m_cell[k] % 16 != 0) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 81; k++) m_cell[k] = 0;
    m_ci = 0; m_cj = 0; m_phase = 0; m_beats = 0; m_rd = 0;
  endtask

  task automatic model_step();
    int rdv = lookup(int'(rd_i), int'(rd_j));
    int d, c;
    if (m_phase == 1) begin
      if (load_valid) begin
        d = int'(load_data);
        if (d % 16 > 9) d = d - (d % 16);
        m_cell[m_beats] = d;
        m_beats++;
        if (m_beats == 81) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else begin
      if (btn_inc) begin
        c = m_cell[m_ci*9 + m_cj];
        if (c < 16) m_cell[m_ci*9 + m_cj] = (c == 9) ? 0 : c + 1;
      end
      if (btn_up && !btn_down) m_ci = (m_ci + 8) % 9;
      if (btn_down && !btn_up) m_ci = (m_ci + 1) % 9;
      if (btn_left && !btn_right) m_cj = (m_cj + 8) % 9;
      if (btn_right && !btn_left) m_cj = (m_cj + 1) % 9;
      if (load_start) begin m_phase = 1; m_beats = 0; end
    end
    m_rd = rdv;
  endtask

  function automatic int exp_rd();
`ifdef COMB_READ_EN
    return lookup(int'(rd_i), int'(rd_j));
`else
    return m_rd;
`endif
  endfunction

  task automatic check_outputs();
    check_val("rd_value", 32'(rd_value), 32'(exp_rd()));
    check_val("cur_i", 32'(cur_i), 32'(m_ci));
    check_val("cur_j", 32'(cur_j), 32'(m_cj));
    check_val("filled_count", 32'(filled_count), 32'(m_filled()));
    check_val("board_full", 32'(board_full), 32'(m_filled() == 81));
    check_val("load_ready", 32'(load_ready), 32'(m_phase == 1));
    check_val("load_done", 32'(load_done), 32'(m_phase == 2));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_pulses();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_inc = 0;
    load_start = 0;
  endtask

  task automatic press(input logic up, input logic down, input logic left,
                       input logic right, input logic inc);
    btn_up = up; btn_down = down; btn_left = left; btn_right = right; btn_inc = inc;
    cycle();
    clear_pulses();
  endtask

  task automatic read_cell(input int i, input int j);
    rd_i = 5'(i); rd_j = 5'(j);
    cycle();
  endtask

  function automatic logic [4:0] rand_word();
    logic [3:0] dig = 4'($urandom_range(0, 15));
    logic       giv = 1'($urandom_range(0, 1));
    if (dig > 4'd9) giv = 1'b0;
    return {giv, dig};
  endfunction

  int ready_cnt, done_cnt, xfers;

  initial begin
    reset = 1'b1;
    rd_i = 0; rd_j = 0; load_valid = 0; load_data = 0;
    clear_pulses();
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Reset state read of (3,4)
    read_cell(3, 4);
    check_val("reset_rd_34", 32'(rd_value), 32'd0);
    check_val("reset_cur", {27'd0, cur_i} * 16 + 32'(cur_j), 32'd0);
    check_val("reset_full", 32'(board_full), 32'd0);

    // Load with valid held high, cell k = {k%2, k%9+1}
    load_start = 1; cycle(); load_start = 0;
    ready_cnt = 0; done_cnt = 0;
    load_valid = 1;
    for (int k = 0; k < 81; k++) begin
      load_data = 5'(((k % 2) << 4) | ((k % 9) + 1));
      if (load_ready) ready_cnt++;
      cycle();
      if (load_done) done_cnt++;
    end
    load_valid = 0;
    for (int k = 0; k < 3; k++) begin
      if (load_ready) ready_cnt++;
      cycle();
      if (load_done) done_cnt++;
    end
    check_val("load1_ready_cycles", 32'(ready_cnt), 32'd81);
    check_val("load1_done_pulses", 32'(done_cnt), 32'd1);
    check_val("load1_filled", 32'(filled_count), 32'd81);
    check_val("load1_full", 32'(board_full), 32'd1);
    read_cell(2, 4);
    check_val("load1_rd_24", 32'(rd_value), 32'h05);

    // Cursor wrap
    press(1, 0, 0, 0, 0);
    check_val("wrap_up_i", 32'(cur_i), 32'd8);
    check_val("wrap_up_j", 32'(cur_j), 32'd0);
    press(0, 0, 1, 0, 0);
    check_val("wrap_left_j", 32'(cur_j), 32'd8);
    press(0, 1, 0, 1, 0);
    check_val("wrap_dr_i", 32'(cur_i), 32'd0);
    check_val("wrap_dr_j", 32'(cur_j), 32'd0);

    // Digit 9 on non-given cell (0,8) wraps to 0
    press(0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 1);
    check_val("inc9_filled", 32'(filled_count), 32'd80);
    read_cell(0, 8);
    check_val("inc9_cell", 32'(rd_value), 32'd0);
    // Given cell (0,1) = 5'h12 is untouched
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 1);
    read_cell(0, 1);
    check_val("given_cell", 32'(rd_value), 32'h12);
    check_val("given_filled", 32'(filled_count), 32'd80);
    // Increment together with a move hits the pre-move cell (0,1 given -> 0,2)
    press(0, 0, 0, 1, 0);
    press(0, 1, 0, 0, 1);
    read_cell(0, 2);

    // Reset, then load with valid toggling and buttons mashed mid-load
    @(negedge clk);
    reset = 1'b1; #1 model_reset(); check_outputs(); #2 reset = 1'b0;
    load_start = 1; cycle(); load_start = 0;
    xfers = 0;
    for (int t = 0; t < 400 && m_phase == 1; t++) begin
      load_valid = 1'(t % 2);
      load_data = rand_word();
      btn_up = 1'($urandom_range(0, 1)); btn_down = 1'($urandom_range(0, 1));
      btn_left = 1'($urandom_range(0, 1)); btn_right = 1'($urandom_range(0, 1));
      btn_inc = 1'($urandom_range(0, 1));
      if (load_valid && load_ready) xfers++;
      cycle();
    end
    clear_pulses();
    load_valid = 0;
    check_val("toggle_load_finished", 32'(m_phase != 1), 32'd1);
    check_val("toggle_xfers", 32'(xfers), 32'd81);
    check_val("toggle_cur_i", 32'(cur_i), 32'd0);
    check_val("toggle_cur_j", 32'(cur_j), 32'd0);
    cycle();
    for (int k = 0; k < 81; k++) read_cell(k / 9, k % 9);

    // Random mixed operation, including out-of-range reads
    for (int t = 0; t < 600; t++) begin
      rd_i = 5'($urandom_range(0, 15)); rd_j = 5'($urandom_range(0, 15));
      btn_up = 1'($urandom_range(0, 3) == 0); btn_down = 1'($urandom_range(0, 3) == 0);
      btn_left = 1'($urandom_range(0, 3) == 0); btn_right = 1'($urandom_range(0, 3) == 0);
      btn_inc = 1'($urandom_range(0, 2) == 0);
      load_start = 1'($urandom_range(0, 99) == 0);
      load_valid = 1'($urandom_range(0, 1));
      load_data = rand_word();
      cycle();
    end
    clear_pulses();
    load_valid = 0;
    for (int t = 0; t < 400 && m_phase != 0; t++) begin
      load_valid = 1; load_data = rand_word();
      cycle();
    end
    load_valid = 0;
    check_val("drain_idle", 32'(m_phase), 32'd0);

    // Reset after 40 beats abandons the load
    load_start = 1; cycle(); load_start = 0;
    load_valid = 1;
    for (int k = 0; k < 40; k++) begin
      load_data = rand_word();
      cycle();
    end
    load_valid = 0;
    reset = 1'b1; #1 model_reset();
    check_outputs();
    check_val("abort_ready", 32'(load_ready), 32'd0);
    check_val("abort_filled", 32'(filled_count), 32'd0);
    #2 reset = 1'b0;
    done_cnt = 0;
    read_cell(9, 0);
    check_val("abort_rd_90", 32'(rd_value), 32'd0);
    if (load_done) done_cnt++;
    for (int k = 0; k < 81; k++) begin
      read_cell(k / 9, k % 9);
      if (load_done) done_cnt++;
    end
    check_val("abort_done_pulses", 32'(done_cnt), 32'd0);
    check_val("abort_last_cell", 32'(rd_value), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
